// File: rtl/axi_dma_rd_arb.sv
// Round-robin arbiter that shares one AXI DMA read engine among requesters.
// Issues one descriptor at a time and steers the returned stream to its owner.
module axi_dma_rd_arb #(
  parameter int NUM_REQ         = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 9,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int REQ_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [AXI_ADDR_WIDTH-1:0]         m_desc_addr,
  output logic [LEN_WIDTH-1:0]              m_desc_len,
  output logic                              m_desc_valid,
  input  logic                              m_desc_ready,
  input  logic                              m_desc_status_valid,
  input  logic [AXIS_DATA_WIDTH-1:0]        s_data_tdata,
  input  logic                              s_data_tvalid,
  output logic                              s_data_tready,
  input  logic                              s_data_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]        out_tdata,
  output logic [NUM_REQ-1:0]                out_tvalid,
  input  logic [NUM_REQ-1:0]                out_tready,
  output logic                              out_tlast,
  output logic                              busy,
  output logic [REQ_W-1:0]                  grant
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [REQ_W-1:0]          ptr_q, ptr_d;
  logic [REQ_W-1:0]          grant_q, grant_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      got_last_q, got_last_d;
  logic                      got_status_q, got_status_d;

  logic [NUM_REQ-1:0]        rot;
  logic                      found;
  logic [REQ_W-1:0]          win;
  logic [AXI_ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]      win_len;
  logic                      last_beat;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  assign rot = (req_valid >> ptr_q)
             | (req_valid << (NUM_REQ - int'(ptr_q)));

  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        win   = REQ_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == REQ_W'(i)) begin
        win_addr = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign last_beat = s_data_tvalid && out_tready[grant_q]
                  && s_data_tlast;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    len_d         = len_q;
    got_last_d    = got_last_q;
    got_status_d  = got_status_q;
    req_ready     = '0;
    req_done      = '0;
    m_desc_valid  = 1'b0;
    s_data_tready = 1'b0;
    out_tvalid    = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = ~rst;
          grant_d        = win;
          addr_d         = win_addr;
          len_d          = win_len;
          state_d        = (win_len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        m_desc_valid = 1'b1;
        if (m_desc_ready) begin
          state_d      = XFER;
          got_last_d   = 1'b0;
          got_status_d = 1'b0;
        end
      end
      XFER: begin
        out_tvalid[grant_q] = s_data_tvalid;
        s_data_tready       = out_tready[grant_q];
        if (last_beat) got_last_d = 1'b1;
        if (m_desc_status_valid) got_status_d = 1'b1;
        // Same-cycle events count, so either order finishes next cycle.
        if (got_last_d && got_status_d) state_d = DONE;
      end
      DONE: begin
        req_done[grant_q] = 1'b1;
        ptr_d   = (grant_q == REQ_W'(NUM_REQ - 1)) ? '0
                : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      got_last_q   <= 1'b0;
      got_status_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      got_last_q   <= got_last_d;
      got_status_q <= got_status_d;
    end
  end

  assign m_desc_addr = addr_q;
  assign m_desc_len  = len_q;
  assign out_tdata   = s_data_tdata;
  assign out_tlast   = s_data_tlast;
  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;

endmodule

// File: tb/tb_axi_dma_rd_arb.sv
// Bench for axi_dma_rd_arb: transaction-level model checked every cycle,
// a small DMA engine emulator, and directed scenarios with literal timing.
module tb_axi_dma_rd_arb;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 9;
  localparam int DW = 32;
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready, req_done;
  logic [AW-1:0]   m_desc_addr;
  logic [LW-1:0]   m_desc_len;
  logic            m_desc_valid;
  logic            m_desc_ready = 1'b1;
  logic            m_desc_status_valid = 1'b0;
  logic [DW-1:0]   s_data_tdata = '0;
  logic            s_data_tvalid = 1'b0;
  logic            s_data_tready;
  logic            s_data_tlast = 1'b0;
  logic [DW-1:0]   out_tdata;
  logic [N-1:0]    out_tvalid;
  logic [N-1:0]    out_tready = '1;
  logic            out_tlast;
  logic            busy;
  logic [RW-1:0]   grant;

  axi_dma_rd_arb #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW),
    .LEN_WIDTH(LW), .AXIS_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_done(req_done),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_status_valid(m_desc_status_valid),
    .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid),
    .s_data_tready(s_data_tready), .s_data_tlast(s_data_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic to_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Observation logs
  int          rdy_cyc[$], rdy_idx[$], dn_cyc[$];
  int          rx_idx[$];
  logic [31:0] rx_dat[$];
  int          done_cnt[N];
  int          desc_cnt = 0;
  int          desc_cyc = -1;

  // Transaction-level model
  bit            m_busy, m_pend, m_due, m_sl, m_ss;
  int            m_owner, m_rr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;

  always @(negedge clk) begin
    int         win;
    logic [N-1:0] e_rdy, e_done, e_tv;
    logic       e_tr, e_xfer, l, s;
    if (rst) begin
      m_busy = 0; m_pend = 0; m_due = 0; m_sl = 0; m_ss = 0;
      m_owner = 0; m_rr = 0; m_addr = '0; m_len = '0;
    end
    win = -1;
    if (!rst && !m_busy)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
    e_xfer = m_busy && !m_pend && !m_due;
    e_rdy = '0;
    if (win >= 0) e_rdy[win] = 1'b1;
    e_done = '0;
    if (m_due) e_done[m_owner] = 1'b1;
    e_tv = '0;
    if (e_xfer) e_tv[m_owner] = s_data_tvalid;
    e_tr = e_xfer && out_tready[m_owner];
    chk("req_ready", req_ready, e_rdy);
    chk("req_done", req_done, e_done);
    chk("m_desc_valid", m_desc_valid, m_pend);
    chk("m_desc_addr", m_desc_addr, m_addr);
    chk("m_desc_len", m_desc_len, m_len);
    chk("s_data_tready", s_data_tready, e_tr);
    chk("out_tvalid", out_tvalid, e_tv);
    chk("busy", busy, m_busy);
    chk("grant", grant, m_owner);
    chk("out_tdata", out_tdata, s_data_tdata);
    chk("out_tlast", out_tlast, s_data_tlast);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin rdy_cyc.push_back(cyc); rdy_idx.push_back(i); end
      if (req_done[i]) begin dn_cyc.push_back(cyc); done_cnt[i]++; end
      if (out_tvalid[i] && out_tready[i]) begin
        rx_idx.push_back(i); rx_dat.push_back(out_tdata);
      end
    end
    if (m_desc_valid) begin desc_cnt++; desc_cyc = cyc; end
    if (!rst) begin
      if (m_due) begin
        m_due = 0; m_busy = 0; m_rr = (m_owner + 1) % N;
      end else if (win >= 0) begin
        m_busy = 1; m_owner = win;
        m_addr = req_addr[win*AW +: AW];
        m_len  = req_len[win*LW +: LW];
        if (m_len == 0) m_due = 1; else m_pend = 1;
      end else if (m_pend) begin
        if (m_desc_ready) begin m_pend = 0; m_sl = 0; m_ss = 0; end
      end else if (e_xfer) begin
        l = m_sl || (s_data_tvalid && out_tready[m_owner] && s_data_tlast);
        s = m_ss || m_desc_status_valid;
        m_sl = l; m_ss = s;
        if (l && s) m_due = 1;
      end
    end
  end

  // DMA engine emulator
  bit          em_act, em_sent;
  int          em_xc, em_left, em_idx;
  logic [31:0] em_base = '0;
  int          cfg_delay = 0, cfg_stat = -1, cfg_sfrom = 0, cfg_slen = 0;

  task automatic drive();
    logic tv;
    tv = em_act && em_xc >= cfg_delay && em_left > 0;
    s_data_tvalid = tv;
    s_data_tlast  = tv && em_left == 1;
    s_data_tdata  = em_base + 32'(em_idx);
    m_desc_status_valid = em_act && !em_sent &&
      ((cfg_stat >= 0) ? (em_xc == cfg_stat) : (tv && em_left == 1));
    out_tready = (em_act && em_xc >= cfg_sfrom &&
                  em_xc < cfg_sfrom + cfg_slen) ? '0 : '1;
  endtask

  task automatic step();
    logic hd, hb, st;
    logic [LW-1:0] ln;
    @(negedge clk);
    hd = m_desc_valid && m_desc_ready;
    hb = s_data_tvalid && s_data_tready;
    st = m_desc_status_valid;
    ln = m_desc_len;
    @(posedge clk);
    #1;
    if (rst) em_act = 0;
    else begin
      if (hb) begin em_left--; em_idx++; end
      if (st) em_sent = 1;
      if (em_act) em_xc++;
      if (hd) begin
        em_act = 1; em_xc = 0; em_idx = 0; em_sent = 0;
        em_left = (int'(ln) + 3) / 4;
      end
      if (em_act && em_left == 0 && em_sent) em_act = 0;
    end
    drive();
  endtask

  task automatic issue(input int r, input logic [31:0] a,
                       input logic [LW-1:0] l, output int t);
    int n0;
    n0 = rdy_cyc.size();
    req_addr[r*AW +: AW] = a;
    req_len[r*LW +: LW]  = l;
    req_valid[r] = 1'b1;
    t = -1;
    for (int k = 0; k < 50 && t < 0; k++) begin
      step();
      if (rdy_cyc.size() > n0) t = rdy_cyc[n0];
    end
    req_valid[r] = 1'b0;
    if (t < 0) to_fail("issue");
  endtask

  task automatic wait_done(input int r, input int n0);
    for (int k = 0; k < 100 && done_cnt[r] <= n0; k++) step();
    if (done_cnt[r] <= n0) to_fail("wait_done");
  endtask

  initial begin
    int t, n0, d0, r0, dc0, dn;
    int exp5[5] = '{0, 1, 2, 3, 0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Round robin with all requesters held valid
    n0 = rdy_cyc.size();
    d0 = dn_cyc.size();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 32'h100 * i;
      req_len[i*LW +: LW]  = 9'd8;
    end
    req_valid = '1;
    for (int k = 0; k < 200 && rdy_cyc.size() < n0 + 5; k++) step();
    req_valid = '0;
    for (int k = 0; k < 100 && dn_cyc.size() < d0 + 5; k++) step();
    chk("rr_grants", rdy_cyc.size() - n0, 5);
    chk("rr_dones", dn_cyc.size() - d0, 5);
    for (int k = 0; k < 5 && n0 + k < rdy_cyc.size(); k++)
      chk("rr_order", rdy_idx[n0+k], exp5[k]);
    for (int k = 0; k < 4 && d0 + k < dn_cyc.size()
                       && n0 + k + 1 < rdy_cyc.size(); k++)
      chk("rr_gap", rdy_cyc[n0+k+1] - dn_cyc[d0+k], 1);

    // Single request, requester 2, 4 beats, status with tlast
    em_base = 32'h10;
    dc0 = desc_cnt; r0 = rx_dat.size(); dn = done_cnt[2];
    issue(2, 32'h1000, 9'd16, t);
    wait_done(2, dn);
    chk("s1_desc_cnt", desc_cnt - dc0, 1);
    chk("s1_desc_cyc", desc_cyc - t, 1);
    chk("s1_done_cyc", dn_cyc[$] - t, 6);
    chk("s1_done_cnt", done_cnt[2] - dn, 1);
    chk("s1_beats", rx_dat.size() - r0, 4);
    for (int k = 0; k < 4 && r0 + k < rx_dat.size(); k++) begin
      chk("s1_beat_idx", rx_idx[r0+k], 2);
      chk("s1_beat_dat", rx_dat[r0+k], 32'h10 + k);
    end

    // Status 5 cycles before tlast
    cfg_delay = 5; cfg_stat = 0; dn = done_cnt[0];
    issue(0, 32'h2000, 9'd4, t);
    wait_done(0, dn);
    chk("st_before_done", dn_cyc[$] - t, 8);

    // Status 5 cycles after tlast
    cfg_delay = 0; cfg_stat = 6; dn = done_cnt[3];
    issue(3, 32'h3000, 9'd8, t);
    wait_done(3, dn);
    chk("st_after_done", dn_cyc[$] - t, 9);

    // Consumer stall for 3 cycles mid-burst
    cfg_stat = -1; cfg_sfrom = 1; cfg_slen = 3;
    em_base = 32'hA0; r0 = rx_dat.size(); dn = done_cnt[1];
    issue(1, 32'h3100, 9'd16, t);
    wait_done(1, dn);
    cfg_slen = 0;
    chk("stall_done", dn_cyc[$] - t, 9);
    chk("stall_beats", rx_dat.size() - r0, 4);
    for (int k = 0; k < 4 && r0 + k < rx_dat.size(); k++) begin
      chk("stall_idx", rx_idx[r0+k], 1);
      chk("stall_dat", rx_dat[r0+k], 32'hA0 + k);
    end

    // Zero-length request, then a normal one
    dc0 = desc_cnt; dn = done_cnt[1];
    issue(1, 32'h4000, 9'd0, t);
    wait_done(1, dn);
    chk("zl_done", dn_cyc[$] - t, 1);
    chk("zl_no_desc", desc_cnt - dc0, 0);
    dn = done_cnt[1];
    issue(1, 32'h4100, 9'd4, t);
    wait_done(1, dn);
    chk("zl_next_desc", desc_cnt - dc0, 1);
    chk("zl_next_done", dn_cyc[$] - t, 3);

    // Reset during transfer after 2 of 4 beats
    em_base = 32'h50; r0 = rx_dat.size(); dn = done_cnt[2];
    issue(2, 32'h5000, 9'd16, t);
    for (int k = 0; k < 50 && rx_dat.size() < r0 + 2; k++) step();
    if (rx_dat.size() < r0 + 2) to_fail("rst_beats");
    rst = 1'b1;
    em_act = 0;
    drive();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_desc_valid", m_desc_valid, 0);
    chk("rst_tready", s_data_tready, 0);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_addr", m_desc_addr, 0);
    step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step();
    chk("rst_no_done", done_cnt[2] - dn, 0);
    n0 = rdy_cyc.size(); dn = done_cnt[1];
    req_len[1*LW +: LW] = 9'd4;
    req_len[3*LW +: LW] = 9'd4;
    req_valid = 4'b1010;
    for (int k = 0; k < 20 && rdy_cyc.size() <= n0; k++) step();
    req_valid = '0;
    if (rdy_cyc.size() > n0) chk("rst_ptr_grant", rdy_idx[n0], 1);
    else to_fail("rst_ptr_grant");
    wait_done(1, dn);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
